// File: rtl/timer_master_pkg.sv
// rtl/timer_master_pkg.sv - register map, control bits, command ops and FSM states for timer_master_seq
package timer_master_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef enum logic [1:0] {
    OP_START_ONESHOT = 2'd0,
    OP_START_CONT    = 2'd1,
    OP_STOP          = 2'd2,
    OP_SNAPSHOT      = 2'd3
  } cmd_op_e;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_W_PL   = 4'd1;
  localparam logic [3:0] ST_W_PH   = 4'd2;
  localparam logic [3:0] ST_GAP    = 4'd3;
  localparam logic [3:0] ST_W_CTRL = 4'd4;
  localparam logic [3:0] ST_W_STOP = 4'd5;
  localparam logic [3:0] ST_W_SNAP = 4'd6;
  localparam logic [3:0] ST_R_SL   = 4'd7;
  localparam logic [3:0] ST_C_SL   = 4'd8;
  localparam logic [3:0] ST_R_SH   = 4'd9;
  localparam logic [3:0] ST_C_SH   = 4'd10;
  localparam logic [3:0] ST_CLR_ST = 4'd11;

endpackage

// File: rtl/timer_master_seq.sv
// rtl/timer_master_seq.sv - Avalon-MM master sequencing an interval timer: program, stop, snapshot, irq service
module timer_master_seq
  import timer_master_pkg::*;
#(
  parameter int          EVT_CNT_W  = 16,
  parameter logic [31:0] PERIOD_MIN = 32'd1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [31:0]          cmd_period,
  output logic [2:0]           m_address,
  output logic                 m_chipselect,
  output logic                 m_write_n,
  output logic [15:0]          m_writedata,
  input  logic [15:0]          m_readdata,
  input  logic                 timer_irq,
  output logic                 evt_pulse,
  output logic [EVT_CNT_W-1:0] evt_count,
  output logic                 snap_valid,
  output logic [31:0]          snap_value,
  output logic                 busy
);

  logic [3:0]  state;
  logic [3:0]  state_nxt;
  logic        cont_q;
  logic [31:0] period_q;
  logic [15:0] snap_lo;
  logic [31:0] snap_q;
  logic        accept;

  assign cmd_ready  = reset_n && (state == ST_IDLE) && !timer_irq;
  assign accept     = cmd_valid && cmd_ready;
  assign busy       = (state != ST_IDLE);
  assign snap_valid = (state == ST_C_SH);
  // High half is forwarded straight from the bus so the value is valid in the pulse cycle.
  assign snap_value = snap_valid ? {m_readdata, snap_lo} : snap_q;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (timer_irq) begin
          state_nxt = ST_CLR_ST;
        end else if (cmd_valid) begin
          case (cmd_op_e'(cmd_op))
            OP_START_ONESHOT, OP_START_CONT: state_nxt = ST_W_PL;
            OP_STOP:                         state_nxt = ST_W_STOP;
            OP_SNAPSHOT:                     state_nxt = ST_W_SNAP;
            default:                         state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_W_PL:   state_nxt = ST_W_PH;
      ST_W_PH:   state_nxt = ST_GAP;
      ST_GAP:    state_nxt = ST_W_CTRL;
      ST_W_SNAP: state_nxt = ST_R_SL;
      ST_R_SL:   state_nxt = ST_C_SL;
      ST_C_SL:   state_nxt = ST_R_SH;
      ST_R_SH:   state_nxt = ST_C_SH;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cont_q    <= 1'b0;
      period_q  <= '0;
      snap_lo   <= '0;
      snap_q    <= '0;
      evt_count <= '0;
      evt_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      evt_pulse <= 1'b0;
      if (accept) begin
        cont_q   <= cmd_op[0];
        period_q <= (cmd_period < PERIOD_MIN) ? PERIOD_MIN : cmd_period;
      end
      if (state == ST_C_SL) snap_lo <= m_readdata;
      if (state == ST_C_SH) snap_q  <= {m_readdata, snap_lo};
      if (state == ST_CLR_ST) begin
        evt_count <= evt_count + EVT_CNT_W'(1);
        evt_pulse <= 1'b1;
      end
    end
  end

  always_comb begin
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_address    = '0;
    m_writedata  = '0;
    case (state)
      ST_W_PL: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = ADDR_PERIODL;
        m_writedata  = period_q[15:0];
      end
      ST_W_PH: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = ADDR_PERIODH;
        m_writedata  = period_q[31:16];
      end
      ST_W_CTRL: begin
        m_chipselect            = 1'b1;
        m_write_n               = 1'b0;
        m_address               = ADDR_CONTROL;
        m_writedata[CTRL_ITO]   = 1'b1;
        m_writedata[CTRL_START] = 1'b1;
        m_writedata[CTRL_CONT]  = cont_q;
      end
      ST_W_STOP: begin
        m_chipselect           = 1'b1;
        m_write_n              = 1'b0;
        m_address              = ADDR_CONTROL;
        m_writedata[CTRL_STOP] = 1'b1;
      end
      ST_W_SNAP: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = ADDR_SNAPL;
      end
      ST_R_SL: begin
        m_chipselect = 1'b1;
        m_address    = ADDR_SNAPL;
      end
      ST_C_SL: m_address = ADDR_SNAPL;
      ST_R_SH: begin
        m_chipselect = 1'b1;
        m_address    = ADDR_SNAPH;
      end
      ST_C_SH: m_address = ADDR_SNAPH;
      ST_CLR_ST: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = ADDR_STATUS;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_timer_master_seq.sv
// tb/tb_timer_master_seq.sv - directed table-driven bench for timer_master_seq with a small timer slave model
module tb_timer_master_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_period = 32'd0;
  logic [2:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [15:0] m_writedata;
  logic [15:0] m_readdata = 16'd0;
  logic        timer_irq = 1'b0;
  logic        evt_pulse;
  logic [3:0]  evt_count;
  logic        snap_valid;
  logic [31:0] snap_value;
  logic        busy;

  always #5 clk = ~clk;

  timer_master_seq #(.EVT_CNT_W(4), .PERIOD_MIN(32'd1)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_period(cmd_period),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .timer_irq(timer_irq),
    .evt_pulse(evt_pulse), .evt_count(evt_count), .snap_valid(snap_valid),
    .snap_value(snap_value), .busy(busy)
  );

  // Timer slave: registered reads of the snapshot, sticky irq cleared by any STATUS write.
  logic [31:0] snap_model = 32'd0;
  logic        irq_raise = 1'b0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_chipselect && m_write_n)
      m_readdata <= (m_address == 3'd4) ? snap_model[15:0] :
                    (m_address == 3'd5) ? snap_model[31:16] : 16'd0;
    if (m_chipselect && !m_write_n && m_address == 3'd0) timer_irq <= 1'b0;
    else if (irq_raise)                                  timer_irq <= 1'b1;
  end

  typedef struct {
    logic       rd;
    logic [2:0] addr;
    logic [15:0] data;
    int         cyc;
  } bus_t;

  bus_t        log_q[$];
  int          n_pulse = 0;
  int          n_snap = 0;
  int          n_status_wr = 0;
  int          snap_cyc = 0;
  logic [31:0] snap_seen = 32'd0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (m_chipselect) log_q.push_back('{m_write_n, m_address, m_writedata, cyc});
      if (m_chipselect && !m_write_n && m_address == 3'd0) n_status_wr++;
      if (evt_pulse) n_pulse++;
      if (snap_valid) begin
        n_snap++;
        snap_seen = snap_value;
        snap_cyc  = cyc;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge once the DUT is idle again.
  task automatic do_cmd(input logic [1:0] op, input logic [31:0] per,
                        output int acc, output int stall, output int lat);
    log_q.delete();
    cmd_op = op; cmd_period = per; cmd_valid = 1'b1; stall = 0;
    while (!cmd_ready && stall < 20) begin @(negedge clk); stall++; end
    if (!cmd_ready) chk("accept_timeout", {31'd0, cmd_ready}, 32'd1);
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'd2; cmd_period = 32'hDEAD_BEEF;
    lat = 0;
    while (busy && lat < 20) begin lat++; @(negedge clk); end
  endtask

  task automatic raise_irq();
    irq_raise = 1'b1;
    @(negedge clk);
    irq_raise = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] per;
    logic [15:0] pl;
    logic [15:0] ph;
    logic [15:0] ctrl;
    int          lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int acc, stall, lat;
    vecs[0] = '{2'd1, 32'h0001_86A0, 16'h86A0, 16'h0001, 16'h0007, 4};
    vecs[1] = '{2'd0, 32'h0000_0000, 16'h0001, 16'h0000, 16'h0005, 4};
    vecs[2] = '{2'd0, 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 16'h0005, 4};
    vecs[3] = '{2'd2, 32'h0000_1234, 16'h0000, 16'h0000, 16'h0008, 1};
    vecs[4] = '{2'd1, 32'h0002_0003, 16'h0003, 16'h0002, 16'h0007, 4};

    repeat (2) @(negedge clk);
    chk("rst_cs", {31'd0, m_chipselect}, 32'd0);
    chk("rst_write_n", {31'd0, m_write_n}, 32'd1);
    chk("rst_addr_data", {13'd0, m_address, m_writedata}, 32'd0);
    chk("rst_ready_busy", {30'd0, cmd_ready, busy}, 32'd0);
    chk("rst_evt", {27'd0, evt_count, evt_pulse}, 32'd0);
    chk("rst_snap", {31'd0, snap_valid}, 32'd0);
    chk("rst_snap_value", snap_value, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 5; i++) begin
      do_cmd(vecs[i].op, vecs[i].per, acc, stall, lat);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      if (vecs[i].op == 2'd2) begin
        chk($sformatf("v%0d_nwr", i), log_q.size(), 1);
        if (log_q.size() >= 1) begin
          chk($sformatf("v%0d_ctrl_addr", i), log_q[0].addr, 3'd1);
          chk($sformatf("v%0d_ctrl_data", i), log_q[0].data, vecs[i].ctrl);
          chk($sformatf("v%0d_ctrl_cyc", i), log_q[0].cyc, acc + 1);
        end
      end else begin
        chk($sformatf("v%0d_nwr", i), log_q.size(), 3);
        if (log_q.size() >= 3) begin
          chk($sformatf("v%0d_pl", i), {log_q[0].rd, log_q[0].addr, log_q[0].data}, {1'b0, 3'd2, vecs[i].pl});
          chk($sformatf("v%0d_ph", i), {log_q[1].rd, log_q[1].addr, log_q[1].data}, {1'b0, 3'd3, vecs[i].ph});
          chk($sformatf("v%0d_ctrl", i), {log_q[2].rd, log_q[2].addr, log_q[2].data}, {1'b0, 3'd1, vecs[i].ctrl});
          chk($sformatf("v%0d_pl_cyc", i), log_q[0].cyc, acc + 1);
          chk($sformatf("v%0d_gap", i), log_q[2].cyc - log_q[1].cyc, 2);
        end
      end
    end

    snap_model = 32'h0001_2345;
    do_cmd(2'd3, 32'd0, acc, stall, lat);
    chk("snap_lat", lat, 5);
    chk("snap_nbus", log_q.size(), 3);
    if (log_q.size() >= 3) begin
      chk("snap_wr", {log_q[0].rd, log_q[0].addr, log_q[0].data}, {1'b0, 3'd4, 16'h0000});
      chk("snap_rd_lo", {log_q[1].rd, log_q[1].addr}, {1'b1, 3'd4});
      chk("snap_rd_hi", {log_q[2].rd, log_q[2].addr}, {1'b1, 3'd5});
      chk("snap_rd_hi_cyc", log_q[2].cyc, acc + 4);
    end
    chk("snap_count", n_snap, 1);
    chk("snap_value", snap_seen, 32'h0001_2345);
    chk("snap_cyc", snap_cyc, acc + 5);

    for (int i = 0; i < 3; i++) begin
      raise_irq();
      repeat (3) @(negedge clk);
    end
    chk("irq3_evt_count", evt_count, 4'd3);
    chk("irq3_pulses", n_pulse, 3);
    chk("irq3_status_wr", n_status_wr, 3);

    raise_irq();
    do_cmd(2'd0, 32'h0000_0010, acc, stall, lat);
    chk("stall_cycles", stall, 2);
    if (log_q.size() >= 2) begin
      chk("stall_first_status", {log_q[0].rd, log_q[0].addr}, {1'b0, 3'd0});
      chk("stall_then_pl", {log_q[1].addr, log_q[1].data}, {3'd2, 16'h0010});
      chk("stall_pl_cyc", log_q[1].cyc, acc + 1);
    end else begin
      chk("stall_nbus", log_q.size(), 4);
    end
    chk("stall_evt_count", evt_count, 4'd4);

    for (int i = 0; i < 13; i++) begin
      raise_irq();
      repeat (3) @(negedge clk);
    end
    chk("wrap_evt_count", evt_count, 4'd1);
    chk("wrap_pulses", n_pulse, 17);

    cmd_op = 2'd1; cmd_period = 32'h1234_5678; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_wph", {m_chipselect, m_address}, {1'b1, 3'd3});
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_cs", {31'd0, m_chipselect}, 32'd0);
    chk("rst_mid_write_n", {31'd0, m_write_n}, 32'd1);
    chk("rst_mid_addr_data", {13'd0, m_address, m_writedata}, 32'd0);
    chk("rst_mid_ready_busy", {30'd0, cmd_ready, busy}, 32'd0);
    chk("rst_mid_evt_count", evt_count, 4'd0);
    @(negedge clk);
    reset_n = 1'b1;
    log_q.delete();
    repeat (6) @(negedge clk);
    chk("rst_mid_no_bus", log_q.size(), 0);
    chk("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
